// File: rtl/register_read_unit_if.sv
// Register read path bus: read request, write-queue slots, execution write ports
// and the registered operand data returned one cycle after the address.
interface register_read_unit_if;
    logic [4:0]  rs_addr, rt_addr;
    logic        rs_float, rt_float;
    logic        slot0_enable, slot1_enable, slot2_enable;
    logic [4:0]  slot0_addr, slot1_addr, slot2_addr;
    logic [31:0] slot0_data, slot1_data, slot2_data;
    logic        slot0_float, slot1_float, slot2_float;
    logic        wr_misc_enable, wr_alu_enable, wr_mem_enable, wr_fpu_enable;
    logic [4:0]  wr_misc_addr, wr_alu_addr, wr_mem_addr, wr_fpu_addr;
    logic [31:0] wr_misc_data, wr_alu_data, wr_mem_data, wr_fpu_data;
    logic        wr_misc_float, wr_alu_float, wr_mem_float, wr_fpu_float;
    logic [31:0] rs_data, rt_data;

    modport master (
        output rs_addr, rt_addr, rs_float, rt_float,
        output slot0_enable, slot1_enable, slot2_enable,
        output slot0_addr, slot1_addr, slot2_addr,
        output slot0_data, slot1_data, slot2_data,
        output slot0_float, slot1_float, slot2_float,
        output wr_misc_enable, wr_alu_enable, wr_mem_enable, wr_fpu_enable,
        output wr_misc_addr, wr_alu_addr, wr_mem_addr, wr_fpu_addr,
        output wr_misc_data, wr_alu_data, wr_mem_data, wr_fpu_data,
        output wr_misc_float, wr_alu_float, wr_mem_float, wr_fpu_float,
        input  rs_data, rt_data
    );

    modport slave (
        input  rs_addr, rt_addr, rs_float, rt_float,
        input  slot0_enable, slot1_enable, slot2_enable,
        input  slot0_addr, slot1_addr, slot2_addr,
        input  slot0_data, slot1_data, slot2_data,
        input  slot0_float, slot1_float, slot2_float,
        input  wr_misc_enable, wr_alu_enable, wr_mem_enable, wr_fpu_enable,
        input  wr_misc_addr, wr_alu_addr, wr_mem_addr, wr_fpu_addr,
        input  wr_misc_data, wr_alu_data, wr_mem_data, wr_fpu_data,
        input  wr_misc_float, wr_alu_float, wr_mem_float, wr_fpu_float,
        output rs_data, rt_data
    );
endinterface

// File: rtl/register_read_unit.sv
// Integer/float register banks with write-queue bypass before the read-stage
// register and execution-port forwarding after it. Port index 0 = rs, 1 = rt.
module register_read_unit (
    input  logic clk,
    input  logic reset,
    register_read_unit_if.slave bus
);
    logic [31:0] int_bank [32];
    logic [31:0] fp_bank  [32];

    logic [1:0][4:0]  rd_addr, lat_addr;
    logic [1:0]       rd_float, lat_float;
    logic [1:0][31:0] byp_data, lat_data, out_data;

    // Slot index 0 = oldest; write-port index 0 = highest priority (misc)
    logic [2:0]       s_en, s_float;
    logic [2:0][4:0]  s_addr;
    logic [2:0][31:0] s_data;
    logic [3:0]       w_en, w_float;
    logic [3:0][4:0]  w_addr;
    logic [3:0][31:0] w_data;

    assign rd_addr  = {bus.rt_addr, bus.rs_addr};
    assign rd_float = {bus.rt_float, bus.rs_float};
    assign s_en     = {bus.slot2_enable, bus.slot1_enable, bus.slot0_enable};
    assign s_float  = {bus.slot2_float, bus.slot1_float, bus.slot0_float};
    assign s_addr   = {bus.slot2_addr, bus.slot1_addr, bus.slot0_addr};
    assign s_data   = {bus.slot2_data, bus.slot1_data, bus.slot0_data};
    assign w_en     = {bus.wr_fpu_enable, bus.wr_mem_enable, bus.wr_alu_enable, bus.wr_misc_enable};
    assign w_float  = {bus.wr_fpu_float, bus.wr_mem_float, bus.wr_alu_float, bus.wr_misc_float};
    assign w_addr   = {bus.wr_fpu_addr, bus.wr_mem_addr, bus.wr_alu_addr, bus.wr_misc_addr};
    assign w_data   = {bus.wr_fpu_data, bus.wr_mem_data, bus.wr_alu_data, bus.wr_misc_data};

    always_comb begin
        byp_data = '0;
        out_data = '0;
        for (int p = 0; p < 2; p++) begin
            byp_data[p] = rd_float[p] ? fp_bank[rd_addr[p]] : int_bank[rd_addr[p]];
            if (!rd_float[p] && rd_addr[p] == 5'd0)
                byp_data[p] = '0;
            // Ascending scan so the youngest matching slot overwrites older ones
            for (int k = 0; k < 3; k++)
                if (s_en[k] && s_addr[k] == rd_addr[p] && s_float[k] == rd_float[p] &&
                    (rd_float[p] || rd_addr[p] != 5'd0))
                    byp_data[p] = s_data[k];

            out_data[p] = lat_data[p];
            for (int w = 3; w >= 0; w--)
                if (w_en[w] && w_addr[w] == lat_addr[p] && w_float[w] == lat_float[p] &&
                    (lat_float[p] || lat_addr[p] != 5'd0))
                    out_data[p] = w_data[w];
        end
    end

    assign bus.rs_data = out_data[0];
    assign bus.rt_data = out_data[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                int_bank[i] <= '0;
                fp_bank[i]  <= '0;
            end
            lat_addr  <= '0;
            lat_float <= '0;
            lat_data  <= '0;
        end else begin
            lat_addr  <= rd_addr;
            lat_float <= rd_float;
            lat_data  <= byp_data;
            if (s_en[0]) begin
                if (s_float[0])
                    fp_bank[s_addr[0]] <= s_data[0];
                else if (s_addr[0] != 5'd0)
                    int_bank[s_addr[0]] <= s_data[0];
            end
        end
    end
endmodule

// File: tb/tb_register_read_unit.sv
// Directed scenarios plus randomized traffic checked against a bank/queue model.
module tb_register_read_unit;
    logic clk, reset;
    int checks = 0, errors = 0;

    register_read_unit_if bus ();
    register_read_unit dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_int [32];
    logic [31:0] m_fp  [32];
    logic [4:0]  m_rs_a, m_rt_a;
    logic        m_rs_f, m_rt_f;
    logic [31:0] m_rs_d, m_rt_d;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin m_int[i] = '0; m_fp[i] = '0; end
        m_rs_a = '0; m_rt_a = '0; m_rs_f = 1'b0; m_rt_f = 1'b0;
        m_rs_d = '0; m_rt_d = '0;
    endtask

    // Value seen by a read in the current cycle: youngest pending write wins over the bank
    function automatic logic [31:0] ref_read(input logic [4:0] a, input logic f);
        logic en [3];
        logic [4:0] ad [3];
        logic [31:0] dt [3];
        logic fl [3];
        en = '{bus.slot0_enable, bus.slot1_enable, bus.slot2_enable};
        ad = '{bus.slot0_addr, bus.slot1_addr, bus.slot2_addr};
        dt = '{bus.slot0_data, bus.slot1_data, bus.slot2_data};
        fl = '{bus.slot0_float, bus.slot1_float, bus.slot2_float};
        if (!f && a == 0) return 32'h0;
        for (int k = 2; k >= 0; k--)
            if (en[k] && ad[k] == a && fl[k] == f) return dt[k];
        return f ? m_fp[a] : m_int[a];
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic f, input logic [31:0] d);
        logic en [4];
        logic [4:0] ad [4];
        logic [31:0] dt [4];
        logic fl [4];
        en = '{bus.wr_misc_enable, bus.wr_alu_enable, bus.wr_mem_enable, bus.wr_fpu_enable};
        ad = '{bus.wr_misc_addr, bus.wr_alu_addr, bus.wr_mem_addr, bus.wr_fpu_addr};
        dt = '{bus.wr_misc_data, bus.wr_alu_data, bus.wr_mem_data, bus.wr_fpu_data};
        fl = '{bus.wr_misc_float, bus.wr_alu_float, bus.wr_mem_float, bus.wr_fpu_float};
        if (!f && a == 0) return d;
        for (int k = 0; k < 4; k++)
            if (en[k] && ad[k] == a && fl[k] == f) return dt[k];
        return d;
    endfunction

    task automatic idle();
        bus.rs_addr = '0; bus.rt_addr = '0; bus.rs_float = 0; bus.rt_float = 0;
        bus.slot0_enable = 0; bus.slot1_enable = 0; bus.slot2_enable = 0;
        bus.slot0_addr = '0; bus.slot1_addr = '0; bus.slot2_addr = '0;
        bus.slot0_data = '0; bus.slot1_data = '0; bus.slot2_data = '0;
        bus.slot0_float = 0; bus.slot1_float = 0; bus.slot2_float = 0;
        bus.wr_misc_enable = 0; bus.wr_alu_enable = 0; bus.wr_mem_enable = 0; bus.wr_fpu_enable = 0;
        bus.wr_misc_addr = '0; bus.wr_alu_addr = '0; bus.wr_mem_addr = '0; bus.wr_fpu_addr = '0;
        bus.wr_misc_data = '0; bus.wr_alu_data = '0; bus.wr_mem_data = '0; bus.wr_fpu_data = '0;
        bus.wr_misc_float = 0; bus.wr_alu_float = 0; bus.wr_mem_float = 0; bus.wr_fpu_float = 0;
    endtask

    // Called just after a negedge with inputs driven: check outputs, then step the model
    task automatic tick();
        logic [31:0] n_rs, n_rt;
        #1;
        chk("rs_model", bus.rs_data, ref_fwd(m_rs_a, m_rs_f, m_rs_d));
        chk("rt_model", bus.rt_data, ref_fwd(m_rt_a, m_rt_f, m_rt_d));
        n_rs = ref_read(bus.rs_addr, bus.rs_float);
        n_rt = ref_read(bus.rt_addr, bus.rt_float);
        @(posedge clk);
        if (!reset) begin
            m_rs_a = bus.rs_addr; m_rs_f = bus.rs_float; m_rs_d = n_rs;
            m_rt_a = bus.rt_addr; m_rt_f = bus.rt_float; m_rt_d = n_rt;
            if (bus.slot0_enable) begin
                if (bus.slot0_float) m_fp[bus.slot0_addr] = bus.slot0_data;
                else if (bus.slot0_addr != 0) m_int[bus.slot0_addr] = bus.slot0_data;
            end
        end
        @(negedge clk);
    endtask

    // Asserted between edges; the following posedge sees reset high and must not write
    task automatic mid_reset();
        #2 reset = 1'b1;
        model_clear();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [4:0] rand_addr();
        return ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
    endfunction

    initial begin
        reset = 1'b1;
        idle();
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state: int r5 / float f5 read as zero
        #1 chk("reset_rs", bus.rs_data, 32'h0);
        bus.rs_addr = 5; bus.rt_addr = 5; bus.rt_float = 1;
        tick();
        idle();
        #1 chk("r5_zero", bus.rs_data, 32'h0);
        chk("f5_zero", bus.rt_data, 32'h0);
        tick();

        // Commit int r3, then read it from the bank alongside float f3
        bus.slot0_enable = 1; bus.slot0_addr = 3; bus.slot0_data = 32'h12345678;
        tick();
        idle(); bus.rs_addr = 3; bus.rt_addr = 3; bus.rt_float = 1;
        tick();
        idle();
        #1 chk("r3_bank", bus.rs_data, 32'h12345678);
        chk("f3_zero", bus.rt_data, 32'h0);
        tick();

        // Slot priority, and bank mismatch on slot1
        bus.slot0_enable = 1; bus.slot0_addr = 7; bus.slot0_data = 32'hAAAA0000;
        bus.slot2_enable = 1; bus.slot2_addr = 7; bus.slot2_data = 32'hBBBB0000;
        bus.rs_addr = 7; bus.rt_addr = 7;
        tick();
        idle();
        #1 chk("slot2_wins", bus.rs_data, 32'hBBBB0000);
        chk("rt_same", bus.rt_data, 32'hBBBB0000);
        bus.slot1_enable = 1; bus.slot1_addr = 7; bus.slot1_float = 1; bus.slot1_data = 32'hDEAD0001;
        bus.rs_addr = 7;
        tick();
        idle();
        #1 chk("bank_mismatch", bus.rs_data, 32'hAAAA0000);
        tick();

        // Forwarding priority on a latched read of r9
        bus.slot0_enable = 1; bus.slot0_addr = 9; bus.slot0_data = 32'h1;
        tick();
        idle(); bus.rs_addr = 9;
        tick();
        bus.wr_alu_enable = 1; bus.wr_alu_addr = 9; bus.wr_alu_data = 32'h22;
        bus.wr_mem_enable = 1; bus.wr_mem_addr = 9; bus.wr_mem_data = 32'h33;
        #1 chk("fwd_alu", bus.rs_data, 32'h22);
        tick();
        bus.wr_alu_enable = 0;
        #1 chk("fwd_mem", bus.rs_data, 32'h33);
        tick();
        bus.wr_mem_enable = 0;
        #1 chk("fwd_none", bus.rs_data, 32'h1);
        tick();

        // int r0 is never bypassed, forwarded or written
        idle();
        bus.slot2_enable = 1; bus.slot2_addr = 0; bus.slot2_data = 32'hFFFFFFFF;
        bus.slot0_enable = 1; bus.slot0_addr = 0; bus.slot0_data = 32'hFFFFFFFF;
        tick();
        idle();
        bus.wr_misc_enable = 1; bus.wr_misc_addr = 0; bus.wr_misc_data = 32'hFFFFFFFF;
        #1 chk("r0_fwd", bus.rs_data, 32'h0);
        tick();
        idle();
        #1 chk("r0_bank", bus.rs_data, 32'h0);
        tick();

        // Float f4 commit wiped by a mid-cycle reset; reset blocks a pending commit
        bus.slot0_enable = 1; bus.slot0_addr = 4; bus.slot0_float = 1; bus.slot0_data = 32'hCAFEBABE;
        tick();
        bus.slot0_addr = 6; bus.slot0_data = 32'h5555AAAA;
        mid_reset();
        idle(); bus.rs_addr = 4; bus.rs_float = 1; bus.rt_addr = 6; bus.rt_float = 1;
        tick();
        idle();
        #1 chk("f4_reset", bus.rs_data, 32'h0);
        chk("f6_no_write", bus.rt_data, 32'h0);
        tick();

        // Randomized traffic over a small address window to force collisions
        for (int n = 0; n < 600; n++) begin
            bus.rs_addr = rand_addr(); bus.rs_float = 1'($urandom);
            bus.rt_addr = ($urandom_range(0, 3) == 0) ? bus.rs_addr : rand_addr();
            bus.rt_float = ($urandom_range(0, 3) == 0) ? bus.rs_float : 1'($urandom);
            bus.slot0_enable = 1'($urandom); bus.slot0_addr = rand_addr();
            bus.slot0_data = $urandom; bus.slot0_float = 1'($urandom);
            bus.slot1_enable = 1'($urandom); bus.slot1_addr = rand_addr();
            bus.slot1_data = $urandom; bus.slot1_float = 1'($urandom);
            bus.slot2_enable = 1'($urandom); bus.slot2_addr = rand_addr();
            bus.slot2_data = $urandom; bus.slot2_float = 1'($urandom);
            bus.wr_misc_enable = ($urandom_range(0, 3) == 0); bus.wr_misc_addr = rand_addr();
            bus.wr_misc_data = $urandom; bus.wr_misc_float = 1'($urandom);
            bus.wr_alu_enable = ($urandom_range(0, 2) == 0); bus.wr_alu_addr = rand_addr();
            bus.wr_alu_data = $urandom; bus.wr_alu_float = 1'($urandom);
            bus.wr_mem_enable = ($urandom_range(0, 2) == 0); bus.wr_mem_addr = rand_addr();
            bus.wr_mem_data = $urandom; bus.wr_mem_float = 1'($urandom);
            bus.wr_fpu_enable = 1'($urandom); bus.wr_fpu_addr = rand_addr();
            bus.wr_fpu_data = $urandom; bus.wr_fpu_float = 1'($urandom);
            if ($urandom_range(0, 99) == 0) mid_reset();
            else tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
